// File: rtl/rr_mux_feeder_if.sv
// rr_mux_feeder_if -- handshake bundle around the two-channel round-robin feeder.
//   a_data/a_valid/a_ready : source A word, valid, taken-this-cycle
//   b_data/b_valid/b_ready : source B word, valid, taken-this-cycle
//   sel                    : mux select toward the 2x1 bus mux (1 = A)
//   out_data/out_valid     : registered selected word and its valid flag
//   out_ready              : consumer accepts out_data this cycle
// modport master : the feeder's view; modport slave : sources + consumer view.
interface rr_mux_feeder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic             sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  a_data, a_valid, b_data, b_valid, out_ready,
        output a_ready, b_ready, sel, out_data, out_valid
    );

    modport slave (
        output a_data, a_valid, b_data, b_valid, out_ready,
        input  a_ready, b_ready, sel, out_data, out_valid
    );
endinterface

// File: rtl/rr_mux_feeder.sv
// rr_mux_feeder -- round-robin feeder in front of the 2x1 bus mux.
// Arbitrates between sources A and B, holding a channel for up to BURST
// consecutive words while the other requests, and registers the selected
// word into a one-entry output stage.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : rr_mux_feeder_if.master (sources, mux select, output stage)
module rr_mux_feeder #(
    parameter int WIDTH = 16,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_mux_feeder_if.master      bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;   // 1 = A held the most recent grant
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    logic space, xfer, a_rdy, b_rdy;
    logic own_valid, oth_valid, burst_end;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        burst_end = 1'b0;
        own_valid = (state_q == GRANT_A) ? bus.a_valid : bus.b_valid;
        oth_valid = (state_q == GRANT_A) ? bus.b_valid : bus.a_valid;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.a_valid && bus.b_valid) begin
                    state_d = last_q ? GRANT_B : GRANT_A;
                    last_d  = !last_q;
                end else if (bus.a_valid) begin
                    state_d = GRANT_A;
                    last_d  = 1'b1;
                end else if (bus.b_valid) begin
                    state_d = GRANT_B;
                    last_d  = 1'b0;
                end
            end
            GRANT_A, GRANT_B: begin
                // A stalled owner (valid but no space) neither counts nor ends its burst.
                if (xfer) begin
                    if (cnt_q < BURST_LAST) cnt_d = cnt_q + 4'd1;
                    else                    burst_end = 1'b1;
                end else if (!own_valid) begin
                    burst_end = 1'b1;
                end
                if (burst_end) begin
                    cnt_d = '0;
                    if (oth_valid) begin
                        state_d = (state_q == GRANT_A) ? GRANT_B : GRANT_A;
                        last_d  = (state_q == GRANT_B);
                    end else if (!own_valid) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        space         = !valid_q || bus.out_ready;
        a_rdy         = (state_q == GRANT_A) && space;
        b_rdy         = (state_q == GRANT_B) && space;
        xfer          = (bus.a_valid && a_rdy) || (bus.b_valid && b_rdy);
        bus.sel       = (state_q == GRANT_A);
        bus.a_ready   = a_rdy;
        bus.b_ready   = b_rdy;
        bus.out_data  = data_q;
        bus.out_valid = valid_q;
    end

    // One-entry output stage; a load and a drain on the same edge keep valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= (state_q == GRANT_A) ? bus.a_data : bus.b_data;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_feeder.sv
module tb_rr_mux_feeder;
    logic clk;
    logic rst;

    rr_mux_feeder_if #(.WIDTH(16)) bus ();

    rr_mux_feeder #(.WIDTH(16), .BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    int a_idx = 0, a_lim = 0, b_idx = 0, b_lim = 0;
    logic a_en = 1'b0, b_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_src();
        bus.a_valid = a_en && (a_idx < a_lim);
        bus.a_data  = 16'hA000 + 16'(a_idx);
        bus.b_valid = b_en && (b_idx < b_lim);
        bus.b_data  = 16'hB000 + 16'(b_idx);
    endtask

    task automatic push_a(input int idx);
        exp_q.push_back(16'hA000 + 16'(idx));
    endtask

    task automatic push_b(input int idx);
        exp_q.push_back(16'hB000 + 16'(idx));
    endtask

    // One clock: score the consumed word at the negedge, advance sources after the edge.
    task automatic tick();
        logic fa, fb;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("sb_extra", 32'(exp_q.size()), 32'd1);
            else                   chk("sb_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        fa = bus.a_valid && bus.a_ready;
        fb = bus.b_valid && bus.b_ready;
        @(posedge clk);
        #1;
        if (fa) a_idx++;
        if (fb) b_idx++;
        update_src();
    endtask

    initial begin
        int a0, b0;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        update_src();

        // Reset state
        tick();
        tick();
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
        chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);

        // A only: no bubbles, burst restarts without a switch
        rst = 1'b0; a_en = 1'b1; a_lim = 10;
        update_src();
        for (int i = 0; i < 10; i++) push_a(i);
        tick();
        chk("t1_sel_e1", 32'(bus.sel), 32'd1);
        chk("t1_a_ready_e1", 32'(bus.a_ready), 32'd1);
        chk("t1_out_valid_e1", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
            chk("t1_sel", 32'(bus.sel), 32'd1);
        end
        tick();
        chk("t1_out_valid_end", 32'(bus.out_valid), 32'd0);
        chk("t1_sel_end", 32'(bus.sel), 32'd0);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // Both valid: A0..A3, B0..B3, A4..A7
        rst = 1'b1;
        tick();
        rst = 1'b0; a0 = a_idx; b0 = b_idx;
        a_lim = a0 + 8; b_lim = b0 + 4; b_en = 1'b1;
        update_src();
        for (int i = 0; i < 4; i++) push_a(a0 + i);
        for (int i = 0; i < 4; i++) push_b(b0 + i);
        for (int i = 4; i < 8; i++) push_a(a0 + i);
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k <= 12) chk("t2_sel", 32'(bus.sel), ((k - 1) / 4) % 2 == 0 ? 32'd1 : 32'd0);
            if (k >= 2)  chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
        end
        tick();
        chk("t2_out_valid_end", 32'(bus.out_valid), 32'd0);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);

        // Output stall for 3 cycles mid-burst, then B joins
        a0 = a_idx; b0 = b_idx;
        a_lim = a0 + 6; b_lim = b0 + 2; b_en = 1'b0;
        update_src();
        for (int i = 0; i < 4; i++) push_a(a0 + i);
        push_b(b0); push_b(b0 + 1);
        push_a(a0 + 4); push_a(a0 + 5);
        tick();
        tick();
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_stall_data", 32'(bus.out_data), 32'(16'hA000 + 16'(a0 + 1)));
            chk("t3_stall_a_ready", 32'(bus.a_ready), 32'd0);
            chk("t3_stall_sel", 32'(bus.sel), 32'd1);
        end
        bus.out_ready = 1'b1; b_en = 1'b1;
        update_src();
        tick();
        chk("t3_sel_e7", 32'(bus.sel), 32'd1);
        tick();
        chk("t3_sel_e8", 32'(bus.sel), 32'd0);
        tick();
        tick();
        tick();
        chk("t3_sel_e11", 32'(bus.sel), 32'd1);
        chk("t3_gap_e11", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Owner A drops valid mid-burst while B requests
        a0 = a_idx; b0 = b_idx;
        a_lim = a0 + 2; b_lim = b0 + 4; b_en = 1'b0;
        update_src();
        push_a(a0); push_a(a0 + 1);
        for (int i = 0; i < 4; i++) push_b(b0 + i);
        for (int i = 2; i < 6; i++) push_a(a0 + i);
        tick();
        b_en = 1'b1;
        update_src();
        chk("t4_sel_e1", 32'(bus.sel), 32'd1);
        tick();
        tick();
        chk("t4_sel_e3", 32'(bus.sel), 32'd1);
        chk("t4_b_ready_e3", 32'(bus.b_ready), 32'd0);
        chk("t4_out_valid_e3", 32'(bus.out_valid), 32'd1);
        tick();
        chk("t4_sel_e4", 32'(bus.sel), 32'd0);
        chk("t4_b_ready_e4", 32'(bus.b_ready), 32'd1);
        chk("t4_gap_e4", 32'(bus.out_valid), 32'd0);
        a_lim = a0 + 6;
        update_src();
        tick();
        tick();
        tick();
        chk("t4_sel_e7", 32'(bus.sel), 32'd0);
        tick();
        chk("t4_sel_e8", 32'(bus.sel), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // Reset while a word is held in GRANT_B
        a_en = 1'b0; b0 = b_idx; b_lim = b0 + 4;
        update_src();
        tick();
        tick();
        chk("t5_held_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_held_data", 32'(bus.out_data), 32'(16'hB000 + 16'(b0)));
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_rst_sel", 32'(bus.sel), 32'd0);
        chk("t5_rst_a_ready", 32'(bus.a_ready), 32'd0);
        chk("t5_rst_b_ready", 32'(bus.b_ready), 32'd0);
        chk("t5_rst_data", 32'(bus.out_data), 32'd0);
        rst = 1'b0; bus.out_ready = 1'b1; a_en = 1'b1;
        a_lim = a_idx + 1; b_lim = b_idx + 1;
        update_src();
        push_a(a_idx); push_b(b_idx);
        tick();
        chk("t5_tie_sel", 32'(bus.sel), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
